// File: rtl/io_output_hs.sv
// io_output_hs: memory-mapped output unit for the pipelined CPU.
// CPU stores load two 32-bit output port registers. Each port hands its data
// to an external consumer with a valid/ack handshake. A status register
// reports pending data, dropped writes (sticky overflow) and 8-bit transfer
// counts, and is cleared by writing ones to its clear bits.
module io_output_hs #(
    parameter logic [5:0] PORT0_SEL = 6'b100000,
    parameter logic [5:0] PORT1_SEL = 6'b100001,
    parameter logic [5:0] STAT_SEL  = 6'b100010
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic        out_valid0,
    output logic        out_valid1,
    input  logic        out_ack0,
    input  logic        out_ack1,
    output logic [31:0] io_read_data
);

    // Status clear bits inside a status-register store.
    localparam int CLR_OVF0_BIT = 2;
    localparam int CLR_OVF1_BIT = 3;
    localparam int CLR_CNT_BIT  = 4;

    // Architectural state.
    logic [31:0] port0_q, port0_d;
    logic [31:0] port1_q, port1_d;
    logic        valid0_q, valid0_d;
    logic        valid1_q, valid1_d;
    logic        ovf0_q, ovf0_d;
    logic        ovf1_q, ovf1_d;
    logic [7:0]  cnt0_q, cnt0_d;
    logic [7:0]  cnt1_q, cnt1_d;

    // Decoded strobes.
    logic [5:0]  word_sel;
    logic        wr_port0;
    logic        wr_port1;
    logic        wr_stat;
    logic        xfer0;
    logic        xfer1;
    logic        accept0;
    logic        accept1;

    // Pack the status word from the current register state.
    function automatic logic [31:0] build_status(
        input logic       v0,
        input logic       v1,
        input logic       o0,
        input logic       o1,
        input logic [7:0] c0,
        input logic [7:0] c1
    );
        build_status = {8'h00, c1, c0, 4'h0, o1, o0, v1, v0};
    endfunction

    // Address decode and handshake events for this cycle.
    always_comb begin
        word_sel = addr[7:2];
        wr_port0 = write_io_enable && (word_sel == PORT0_SEL);
        wr_port1 = write_io_enable && (word_sel == PORT1_SEL);
        wr_stat  = write_io_enable && (word_sel == STAT_SEL);
        // A transfer needs data actually pending; an ack on an empty port is ignored.
        xfer0    = valid0_q && out_ack0;
        xfer1    = valid1_q && out_ack1;
        // A store is taken when the port is empty or is being drained this cycle.
        accept0  = wr_port0 && (!valid0_q || out_ack0);
        accept1  = wr_port1 && (!valid1_q || out_ack1);
    end

    // Port 0 next state: refill, drain, or flag a dropped store.
    always_comb begin
        port0_d  = port0_q;
        valid0_d = valid0_q;
        ovf0_d   = ovf0_q;
        if (accept0) begin
            port0_d  = datain;
            valid0_d = 1'b1;
        end else if (xfer0) begin
            valid0_d = 1'b0;
        end
        if (wr_port0 && !accept0) begin
            ovf0_d = 1'b1;
        end
        if (wr_stat && datain[CLR_OVF0_BIT]) begin
            ovf0_d = 1'b0;
        end
    end

    // Port 1 next state: refill, drain, or flag a dropped store.
    always_comb begin
        port1_d  = port1_q;
        valid1_d = valid1_q;
        ovf1_d   = ovf1_q;
        if (accept1) begin
            port1_d  = datain;
            valid1_d = 1'b1;
        end else if (xfer1) begin
            valid1_d = 1'b0;
        end
        if (wr_port1 && !accept1) begin
            ovf1_d = 1'b1;
        end
        if (wr_stat && datain[CLR_OVF1_BIT]) begin
            ovf1_d = 1'b0;
        end
    end

    // Transfer counters; a counter clear overrides a same-cycle increment.
    always_comb begin
        cnt0_d = cnt0_q + {7'd0, xfer0};
        cnt1_d = cnt1_q + {7'd0, xfer1};
        if (wr_stat && datain[CLR_CNT_BIT]) begin
            cnt0_d = 8'h00;
            cnt1_d = 8'h00;
        end
    end

    // State registers; reset takes priority over any store or ack.
    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            port0_q  <= 32'h0;
            port1_q  <= 32'h0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
            cnt0_q   <= 8'h00;
            cnt1_q   <= 8'h00;
        end else begin
            port0_q  <= port0_d;
            port1_q  <= port1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            ovf0_q   <= ovf0_d;
            ovf1_q   <= ovf1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Registered outputs; no path from the ack inputs reaches these.
    always_comb begin
        out_port0  = port0_q;
        out_port1  = port1_q;
        out_valid0 = valid0_q;
        out_valid1 = valid1_q;
    end

    // CPU load readback from the pre-edge register state.
    always_comb begin
        io_read_data = 32'h0;
        if (word_sel == PORT0_SEL) begin
            io_read_data = port0_q;
        end else if (word_sel == PORT1_SEL) begin
            io_read_data = port1_q;
        end else if (word_sel == STAT_SEL) begin
            io_read_data = build_status(valid0_q, valid1_q, ovf0_q, ovf1_q, cnt0_q, cnt1_q);
        end
    end

endmodule

// File: tb/tb_io_output_hs.sv
// Testbench for io_output_hs: directed handshake scenarios followed by random
// stores/acks/resets, all checked against a behavioural model of the ports.
module tb_io_output_hs;

    logic        io_clk;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic        out_valid0;
    logic        out_valid1;
    logic        out_ack0;
    logic        out_ack1;
    logic [31:0] io_read_data;

    int n_cmp;
    int n_mis;

    // Reference model state, indexed by port number.
    logic [31:0] m_port  [2];
    logic        m_valid [2];
    logic        m_ovf   [2];
    int          m_cnt   [2];

    io_output_hs dut (
        .io_clk          (io_clk),
        .resetn          (resetn),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .out_port0       (out_port0),
        .out_port1       (out_port1),
        .out_valid0      (out_valid0),
        .out_valid1      (out_valid1),
        .out_ack0        (out_ack0),
        .out_ack1        (out_ack1),
        .io_read_data    (io_read_data)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        return (m_valid[0] ? 32'd1 : 32'd0) + (m_valid[1] ? 32'd2 : 32'd0)
             + (m_ovf[0] ? 32'd4 : 32'd0) + (m_ovf[1] ? 32'd8 : 32'd0)
             + 32'(m_cnt[0]) * 256 + 32'(m_cnt[1]) * 65536;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'(a[7:2]);
        if (w == 32) return m_port[0];
        if (w == 33) return m_port[1];
        if (w == 34) return model_status();
        return 32'h0;
    endfunction

    // Apply one clock of the handshake rules to the model.
    task automatic model_clock(input logic rstn, input logic [31:0] a, input logic [31:0] d,
                               input logic we, input logic ak0, input logic ak1);
        logic ack [2];
        int   w;
        ack[0] = ak0;
        ack[1] = ak1;
        w = int'(a[7:2]);
        if (!rstn) begin
            for (int n = 0; n < 2; n++) begin
                m_port[n] = 0; m_valid[n] = 0; m_ovf[n] = 0; m_cnt[n] = 0;
            end
            return;
        end
        for (int n = 0; n < 2; n++) begin
            logic xfer;
            xfer = m_valid[n] && ack[n];
            if (xfer) m_cnt[n] = (m_cnt[n] + 1) % 256;
            if (we && w == 32 + n) begin
                if (!m_valid[n] || ack[n]) begin
                    m_port[n]  = d;
                    m_valid[n] = 1;
                end else begin
                    m_ovf[n] = 1;
                end
            end else if (xfer) begin
                m_valid[n] = 0;
            end
        end
        if (we && w == 34) begin
            if (d[2]) m_ovf[0] = 0;
            if (d[3]) m_ovf[1] = 0;
            if (d[4]) begin m_cnt[0] = 0; m_cnt[1] = 0; end
        end
    endtask

    // One bus cycle: check the load path before the edge, then all state after it.
    task automatic step(input logic rstn, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic ak0, input logic ak1);
        logic [31:0] exp_rd;
        resetn = rstn; addr = a; datain = d; write_io_enable = we;
        out_ack0 = ak0; out_ack1 = ak1;
        exp_rd = model_read(a);
        #1;
        chk("read_pre_edge", io_read_data, exp_rd);
        @(posedge io_clk);
        model_clock(rstn, a, d, we, ak0, ak1);
        #1;
        chk("port0", out_port0, m_port[0]);
        chk("port1", out_port1, m_port[1]);
        chk("valid0", {31'd0, out_valid0}, {31'd0, m_valid[0]});
        chk("valid1", {31'd0, out_valid1}, {31'd0, m_valid[1]});
        resetn = 1'b1; write_io_enable = 1'b0; addr = 32'h88;
        #1;
        chk("status", io_read_data, model_status());
    endtask

    // Combinational load without a clock edge; compared to a fixed value.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        write_io_enable = 1'b0; addr = a;
        #1;
        chk(tag, io_read_data, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  sel;
        int          pick;
        n_cmp = 0; n_mis = 0;
        for (int n = 0; n < 2; n++) begin
            m_port[n] = 0; m_valid[n] = 0; m_ovf[n] = 0; m_cnt[n] = 0;
        end
        resetn = 1'b0; addr = 0; datain = 0; write_io_enable = 0;
        out_ack0 = 0; out_ack1 = 0;
        @(negedge io_clk);

        // Reset state.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_port0", out_port0, 32'h0);
        chk("rst_valid0", {31'd0, out_valid0}, 32'h0);
        peek("rst_status", 32'h88, 32'h0);

        // First store to port 0.
        step(1'b1, 32'h80, 32'h12345678, 1'b1, 1'b0, 1'b0);
        chk("wr0_port0", out_port0, 32'h12345678);
        chk("wr0_valid0", {31'd0, out_valid0}, 32'h1);
        peek("wr0_status", 32'h88, 32'h00000001);
        peek("wr0_load80", 32'h80, 32'h12345678);

        // Transfer, then an ignored ack on an empty port.
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("xfer_valid0", {31'd0, out_valid0}, 32'h0);
        peek("xfer_status", 32'h88, 32'h00000100);
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        peek("idle_ack_status", 32'h88, 32'h00000100);

        // Clear counters, then overflow on port 1 and clear it.
        step(1'b1, 32'h88, 32'h10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h84, 32'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h84, 32'hB, 1'b1, 1'b0, 1'b0);
        chk("ovf_port1", out_port1, 32'hA);
        peek("ovf_status", 32'h88, 32'h0000000A);
        step(1'b1, 32'h88, 32'h8, 1'b1, 1'b0, 1'b0);
        chk("ovfclr_valid1", {31'd0, out_valid1}, 32'h1);
        peek("ovfclr_status", 32'h88, 32'h00000002);

        // Refill in the same cycle as a transfer.
        step(1'b1, 32'h80, 32'h55, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h80, 32'hC, 1'b1, 1'b1, 1'b0);
        chk("refill_port0", out_port0, 32'hC);
        chk("refill_valid0", {31'd0, out_valid0}, 32'h1);
        peek("refill_status", 32'h88, 32'h00000103);

        // 256 port-1 transfers wrap cnt1; counter clear beats a port-0 increment.
        step(1'b1, 32'h88, 32'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 32'h84, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b1);
        end
        peek("wrap_status", 32'h88, 32'h00000003);
        step(1'b1, 32'h88, 32'h10, 1'b1, 1'b1, 1'b0);
        peek("clr_vs_xfer_status", 32'h88, 32'h00000002);

        // Reset mid-handshake with a simultaneous store, then an unmapped store.
        step(1'b0, 32'h80, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        chk("rst2_port0", out_port0, 32'h0);
        chk("rst2_port1", out_port1, 32'h0);
        chk("rst2_valid1", {31'd0, out_valid1}, 32'h0);
        peek("rst2_status", 32'h88, 32'h0);
        step(1'b1, 32'h8C, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        peek("unmapped_load", 32'h8C, 32'h0);
        peek("unmapped_status", 32'h88, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            pick = int'($urandom_range(0, 5));
            case (pick)
                0, 1:    sel = 6'h20;
                2:       sel = 6'h21;
                3:       sel = 6'h22;
                4:       sel = 6'h23;
                default: sel = 6'(r[13:8]);
            endcase
            step(($urandom_range(0, 39) != 0), {r[31:8], sel, r[1:0]}, $urandom,
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/io_output_hs.md
Name: io_output_hs

Overview:
- Memory-mapped output unit for the pipelined CPU; the store-side counterpart of the memory-mapped input ports.
- CPU stores (addr[7:2] decode) load two 32-bit output port registers.
- Each port presents data to an external consumer with a valid/ack handshake.
- A status register, readable and write-1-to-clear, reports pending data, dropped writes (overflow) and transfer counts.

Parameters:
- PORT0_SEL, 6'b100000, addr[7:2] value selecting output port 0
- PORT1_SEL, 6'b100001, addr[7:2] value selecting output port 1
- STAT_SEL, 6'b100010, addr[7:2] value selecting status register

Ports:
- io_clk  input  1  single clock, all state updates on posedge
- resetn  input  1  synchronous active-low reset
- addr  input  32  CPU data address; only addr[7:2] decoded
- datain  input  32  CPU store data
- write_io_enable  input  1  store strobe for the I/O space, sampled on posedge
- out_port0  output  32  port 0 data register
- out_port1  output  32  port 1 data register
- out_valid0  output  1  port 0 holds untransferred data
- out_valid1  output  1  port 1 holds untransferred data
- out_ack0  input  1  consumer accepts port 0 data
- out_ack1  input  1  consumer accepts port 1 data
- io_read_data  output  32  combinational readback for CPU loads

Behaviour:
- Reset (resetn=0 at posedge): out_port0/1=0, out_valid0/1=0, ovf0/1=0, cnt0/1=0. Reset has priority over every other event, including a write or ack in the same cycle.
- Write accept: write_io_enable=1 at posedge. addr[7:2] selects PORTn_SEL, STAT_SEL, or nothing. Any other address is ignored with no state change.
- Transfer: occurs on a posedge with validN=1 and ackN=1. cntN increments by 1 (8-bit, 0xFF wraps to 0x00), and validN clears unless refilled in the same cycle. ackN while validN=0 is ignored.
- Port write rules (port N):
  - validN=0: out_portN<=datain; validN<=1. Visible the next cycle (1-cycle latency).
  - validN=1 and ackN=1 in the same cycle: the transfer completes (cntN++), out_portN<=datain, and validN stays 1.
  - validN=1 and ackN=0: the write is dropped, out_portN is unchanged, and ovfN<=1 (sticky).
- Ports are independent; both may transfer in the same cycle.
- Status word: bit0 valid0, bit1 valid1, bit2 ovf0, bit3 ovf1, bits[7:4]=0, bits[15:8] cnt0, bits[23:16] cnt1, bits[31:24]=0.
- Status write:
  - datain[2]=1 clears ovf0; datain[3]=1 clears ovf1.
  - datain[4]=1 clears cnt0 and cnt1. The clear wins over a same-cycle transfer increment: the counter reads 0 afterwards.
  - Other datain bits are ignored.
  - A status write does not touch the valid bits or the ports.
- io_read_data (combinational, no clock):
  - addr[7:2]=PORT0_SEL -> out_port0; PORT1_SEL -> out_port1; STAT_SEL -> status word; else 0.
  - Reflects register state before the current edge.
- No combinational path from ackN to out_validN. All outputs except io_read_data are registered.

Test Plan:
- Reset, then store 0x12345678 to addr 0x80 with ack0=0 -> the next cycle shows out_port0=0x12345678, out_valid0=1. Load of 0x88 returns 0x00000001.
- Hold ack0=1 for one cycle -> out_valid0=0 and status bits[15:8]=0x01. A second ack with valid0=0 leaves cnt0=1.
- Store 0xA to 0x84, then store 0xB to 0x84 with ack1=0 -> out_port1 stays 0xA, ovf1=1, status=0x0000000A. Store datain=0x8 to 0x88 -> ovf1=0, valid1 still 1.
- Store 0xC to 0x80 in the same cycle as ack0=1 with valid0=1 -> cnt0 increments, out_port0=0xC, out_valid0 stays 1.
- Perform 256 transfers on port 1 -> cnt1 wraps to 0x00. Store datain=0x10 to 0x88 in the same cycle as a port-0 transfer -> cnt0=0 afterwards.
- Assert resetn=0 mid-handshake with a simultaneous store to 0x80 -> all outputs and status are 0 the next cycle. Store to 0x8C -> no state change, and a load of 0x8C returns 0.
